// File: rtl/pc_pkg.sv
// Shared constants and the PC type for the miniMIPS next-PC logic.
package pc_pkg;

  localparam int unsigned PC_WIDTH  = 6;
  localparam int unsigned IMM_WIDTH = 32;
  localparam int unsigned PC_STEP   = 4;
  localparam int unsigned RESET_PC  = 0;

  typedef logic [PC_WIDTH-1:0] pc_t;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: PC+STEP, or PC+STEP+offset when branching.
// Only the low PC_WIDTH bits of the immediate take part; all arithmetic wraps.
module pc_next_calc
  import pc_pkg::*;
#(
  parameter int unsigned PC_WIDTH  = pc_pkg::PC_WIDTH,
  parameter int unsigned IMM_WIDTH = pc_pkg::IMM_WIDTH,
  parameter int unsigned PC_STEP   = pc_pkg::PC_STEP
) (
  input  logic [PC_WIDTH-1:0]  program_counter,
  input  logic [IMM_WIDTH-1:0] shifted_immediate_extended,
  input  logic                 branch,
  output logic [PC_WIDTH-1:0]  next
);

  logic [PC_WIDTH-1:0] seq;
  logic [PC_WIDTH-1:0] tgt;
  logic                unused_imm_hi;

  // Upper immediate bits cannot affect a modulo-2^PC_WIDTH result.
  assign unused_imm_hi = ^shifted_immediate_extended[IMM_WIDTH-1:PC_WIDTH];

  // Sequential and branch targets, both truncated to the PC width.
  always_comb begin
    seq  = program_counter + PC_WIDTH'(PC_STEP);
    tgt  = seq + shifted_immediate_extended[PC_WIDTH-1:0];
    next = branch ? tgt : seq;
  end

endmodule

// File: rtl/program_counter_unit.sv
// PC register for the miniMIPS single-cycle datapath.
// Define PC_ALIGN_CHECK_EN to add the registered pc_misaligned flag output.
module program_counter_unit
  import pc_pkg::*;
#(
  parameter int unsigned PC_WIDTH  = pc_pkg::PC_WIDTH,
  parameter int unsigned IMM_WIDTH = pc_pkg::IMM_WIDTH,
  parameter int unsigned PC_STEP   = pc_pkg::PC_STEP,
  parameter int unsigned RESET_PC  = pc_pkg::RESET_PC
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PC_WIDTH-1:0]  program_counter,
  input  logic [IMM_WIDTH-1:0] shifted_immediate_extended,
  input  logic                 branch,
`ifdef PC_ALIGN_CHECK_EN
  output logic                 pc_misaligned,
`endif
  output logic [PC_WIDTH-1:0]  new_program_counter
);

  logic [PC_WIDTH-1:0] pc_d;
  logic [PC_WIDTH-1:0] pc_q;

  pc_next_calc #(
    .PC_WIDTH  (PC_WIDTH),
    .IMM_WIDTH (IMM_WIDTH),
    .PC_STEP   (PC_STEP)
  ) u_next (
    .program_counter            (program_counter),
    .shifted_immediate_extended (shifted_immediate_extended),
    .branch                     (branch),
    .next                       (pc_d)
  );

  // Next PC register; asynchronous reset overrides any pending update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= PC_WIDTH'(RESET_PC);
    else        pc_q <= pc_d;
  end

  assign new_program_counter = pc_q;

`ifdef PC_ALIGN_CHECK_EN
  logic mis_d;
  logic mis_q;

  assign mis_d = (pc_d[1:0] != 2'b00);

  // Alignment flag registered alongside the PC it describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mis_q <= 1'b0;
    else        mis_q <= mis_d;
  end

  assign pc_misaligned = mis_q;
`endif

endmodule

// File: tb/tb_program_counter_unit.sv
// Scoreboard bench for program_counter_unit: stimulus pushes expected values,
// a monitor pops and compares at each falling edge or on an async-check event.
module tb_program_counter_unit;

  logic        clk;
  logic        rst_n;
  logic [5:0]  program_counter;
  logic [31:0] shifted_immediate_extended;
  logic        branch;
  logic [5:0]  new_program_counter;
`ifdef PC_ALIGN_CHECK_EN
  logic        pc_misaligned;
`endif

  typedef struct {
    string      name;
    logic [5:0] pc;
    logic       mis;
  } exp_t;

  exp_t q[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  event chk_ev;

  program_counter_unit #(
    .PC_WIDTH  (6),
    .IMM_WIDTH (32),
    .PC_STEP   (4),
    .RESET_PC  (0)
  ) dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .program_counter            (program_counter),
    .shifted_immediate_extended (shifted_immediate_extended),
    .branch                     (branch),
`ifdef PC_ALIGN_CHECK_EN
    .pc_misaligned              (pc_misaligned),
`endif
    .new_program_counter        (new_program_counter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare the oldest expectation whenever a check point arrives.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or chk_ev);
      if (q.size() > 0) begin
        e = q.pop_front();
        tests_run++;
        if (new_program_counter !== e.pc) begin
          tests_failed++;
          $display("FAIL %s: new_program_counter got %0d expected %0d", e.name, new_program_counter, e.pc);
        end
`ifdef PC_ALIGN_CHECK_EN
        else if (pc_misaligned !== e.mis) begin
          tests_failed++;
          $display("FAIL %s: pc_misaligned got %b expected %b", e.name, pc_misaligned, e.mis);
        end
`endif
      end
    end
  end

  function automatic void push(input string name, input logic [5:0] pc, input logic mis);
    exp_t e;
    e.name = name;
    e.pc   = pc;
    e.mis  = mis;
    q.push_back(e);
  endfunction

  // Drive one clocked vector after a falling edge; result is checked one edge later.
  task automatic drive(input string name, input logic [5:0] pc, input logic [31:0] imm,
                       input logic br, input logic [5:0] exp_pc, input logic exp_mis);
    @(negedge clk);
    #1;
    program_counter            = pc;
    shifted_immediate_extended = imm;
    branch                     = br;
    push(name, exp_pc, exp_mis);
  endtask

  initial begin
    rst_n                      = 1'b0;
    program_counter            = 6'd7;
    shifted_immediate_extended = 32'h0;
    branch                     = 1'b0;

    // Reset is visible without any clock edge.
    #3;
    push("reset_immediate", 6'd0, 1'b0);
    ->chk_ev;

    // Held while rst_n stays low across an edge.
    drive("reset_held", 6'd7, 32'h0, 1'b0, 6'd0, 1'b0);

    // Release: first edge after deassertion loads 7+4.
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    push("reset_release", 6'd11, 1'b1);

    drive("seq_imm_ignored", 6'd7,  32'hFFFF_FFFF, 1'b0, 6'd11, 1'b1);
    drive("fwd_branch",      6'd4,  32'h0000_0007, 1'b1, 6'd15, 1'b1);

    // Async reset between edges while output is 15.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    push("async_reset_mid", 6'd0, 1'b0);
    ->chk_ev;
    #1;
    rst_n = 1'b1;
    push("after_async_release", 6'd15, 1'b1);

    drive("bwd_branch",    6'd20, 32'hFFFF_FFF0, 1'b1, 6'd8,  1'b0);
    drive("wrap_seq",      6'd60, 32'h0,         1'b0, 6'd0,  1'b0);
    drive("wrap_neg_br",   6'd0,  32'hFFFF_FFF8, 1'b1, 6'd60, 1'b0);
    drive("unaligned_seq", 6'd1,  32'h0,         1'b0, 6'd5,  1'b1);
    drive("aligned_seq",   6'd8,  32'h0000_0003, 1'b0, 6'd12, 1'b0);
    drive("upper_imm_br",  6'd0,  32'h0000_0100, 1'b1, 6'd4,  1'b0);
    drive("wrap_branch",   6'd56, 32'h0000_0008, 1'b1, 6'd4,  1'b0);
    drive("odd_branch",    6'd12, 32'h0000_0001, 1'b1, 6'd17, 1'b1);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      tests_failed++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog against any unexpected hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
